cpu8_sequencer: RTL
===================

Name: cpu8_sequencer

Overview:
- Program sequencer for the 8-bit accumulator datapath.
- Holds a small program store loaded over a valid/ready port and, on `start`, fetches words in order.
- ALU words (opcode 0x1–0x5) go to the datapath instruction input; branch and halt words are executed locally using the datapath's accumulator-zero flag.
- Sits between the top-level I/O pins and the accumulator datapath.

Parameters:
- DEPTH, 16: program store entries; power of 2, max 16 because the jump target is the 4-bit operand field.
- AW, 4: address width; equals log2(DEPTH).
- SETTLE_CYC, 3: cycles from issuing an ALU word until `dp_acc_zero` reflects it.
- MAX_STEPS, 255: instruction-count limit per run (watchdog); 8-bit counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- load_req  in  1  enter LOAD from IDLE; ignored in other states.
- ld_valid  in  1  load word valid.
- ld_ready  out  1  load word accepted when ld_valid && ld_ready.
- ld_data  in  8  program word: [3:0] opcode, [7:4] operand.
- ld_last  in  1  qualifies the final load word.
- start  in  1  begin run at pc=0 from IDLE; ignored elsewhere.
- stop  in  1  abort a run or load and return to IDLE; highest priority after rst.
- dp_word  out  8  word to the datapath; 0x00 when dp_valid=0.
- dp_valid  out  1  dp_word carries an ALU op this cycle.
- dp_acc_zero  in  1  datapath accumulator == 0.
- pc  out  AW  current fetch address.
- busy  out  1  state is LOAD, RUN or SETTLE.
- done  out  1  one-cycle pulse when a run ends normally.
- err  out  1  sticky; cleared by rst or by the next accepted start.

Behaviour:
- Reset:
  - State is IDLE.
  - pc, ld_addr, step_cnt and settle_cnt are 0.
  - dp_word=0x00; dp_valid, ld_ready, busy, done and err are 0.
  - Store contents are not reset.
- Opcodes:
  - 0x0 NOP: no issue; pc+1.
  - 0x1–0x5 ALU: dp_valid=1 and dp_word=word for exactly one cycle; pc+1; settle_cnt loaded with SETTLE_CYC.
  - 0x6 JZ: if dp_acc_zero, pc=operand[AW-1:0], else pc+1.
  - 0x7 JNZ: inverse condition of JZ.
  - 0x8 HALT: end the run normally.
  - 0x9–0xF: illegal; err=1, then IDLE; no done pulse.
- IDLE:
  - load_req → LOAD with ld_addr=0.
  - Otherwise start → RUN with pc=0, step_cnt=0, err=0.
  - load_req has priority when both are high.
- LOAD:
  - ld_ready=1.
  - On each handshake, mem[ld_addr]=ld_data and ld_addr+1.
  - Handshake with ld_last=1, or at ld_addr=DEPTH-1 → IDLE.
  - Unwritten entries keep their old contents.
- RUN:
  - One word evaluated per cycle from the combinational read mem[pc].
  - settle_cnt decrements every cycle while nonzero.
  - JZ/JNZ with settle_cnt≠0 → SETTLE; pc holds and nothing is issued.
- SETTLE:
  - Wait until settle_cnt=0, then return to RUN and re-evaluate the same branch.
- Run end:
  - HALT → done pulse, IDLE.
  - A non-branch word at pc=DEPTH-1 executes, then done pulse and IDLE; no wrap.
  - A taken branch may target any address, including backward.
- Watchdog:
  - step_cnt increments per evaluated word, not per SETTLE cycle.
  - Reaching MAX_STEPS → err=1, IDLE, no done.
- stop:
  - In LOAD, RUN or SETTLE → IDLE next cycle.
  - dp_valid is forced to 0 in that cycle.
  - A partial load keeps the words already written; no done pulse.
- rst mid-run or mid-load: same as reset.
- Ordering: the datapath sees words strictly in program order, at most one per cycle.

Optional Feature:
- Macro: CPU8_SEQ_SINGLE_STEP_EN.
- Defined:
  - Adds input `step` (1 bit) and input `step_mode` (1 bit).
  - With step_mode=1, RUN evaluates one word only on a cycle where step=1; otherwise it holds pc and issues nothing.
  - SETTLE countdown is unaffected; the watchdog counts only evaluated words.
- Undefined: the ports are absent and RUN free-runs.

Decomposition:
- Shared package `cpu8_pkg` holds:
  - Opcode localparams: OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT, OP_JZ, OP_JNZ, OP_HALT.
  - Field positions: OPC [3:0], OPND [7:4].
  - The state encoding: IDLE, LOAD, RUN, SETTLE.
- The datapath reuses the same opcode constants.
- One sub-module, `cpu8_prog_mem`:
  - DEPTH×8 register file, single write port, combinational read.
  - No reset of contents.

Test Plan:
- Load 0x31, 0x21, 0x08 with ld_last on the third word, then start → dp_word 0x31 then 0x21 on consecutive cycles, dp_valid high 2 cycles total, done pulse at the HALT cycle, busy low afterward.
- Load 0x11, 0x06 (JZ 0) with dp_acc_zero held 0 → 0x11 issued, 3 SETTLE cycles, then fall-through to pc=2.
- Same program with dp_acc_zero=1 → pc returns to 0; the loop repeats until step_cnt=255, then err=1, no done.
- Load 0x0B → err=1 on the first evaluated word, IDLE, dp_valid never asserted; the next start clears err.
- Assert stop during RUN at pc=5 → IDLE next cycle, dp_valid=0, done=0. Assert rst during LOAD after 2 words → ld_ready=0 and pc=0 next cycle.
- Fill all 16 entries with 0x11, no ld_last → LOAD exits after the 16th handshake; run issues 16 words, then done pulse with pc held at 15.

Source files
------------

// File: rtl/cpu8_pkg.sv
// Shared opcode, field and state definitions for the cpu8 sequencer and datapath.
package cpu8_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_NOT  = 4'h5;
  localparam logic [3:0] OP_JZ   = 4'h6;
  localparam logic [3:0] OP_JNZ  = 4'h7;
  localparam logic [3:0] OP_HALT = 4'h8;

  localparam int unsigned OPC_LSB  = 0;
  localparam int unsigned OPC_MSB  = 3;
  localparam int unsigned OPND_LSB = 4;
  localparam int unsigned OPND_MSB = 7;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    SETTLE
  } seq_state_e;

  function automatic logic is_alu(input logic [3:0] opc);
    return (opc >= OP_ADD) && (opc <= OP_NOT);
  endfunction

endpackage

// File: rtl/cpu8_prog_mem.sv
// Program store: DEPTH x 8 register file, one write port, combinational read, no reset.
module cpu8_prog_mem #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/cpu8_sequencer.sv
// Program sequencer for the 8-bit accumulator datapath.
// Optional single-step control: define CPU8_SEQ_SINGLE_STEP_EN.
module cpu8_sequencer
  import cpu8_pkg::*;
#(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned AW         = 4,
  parameter int unsigned SETTLE_CYC = 3,
  parameter int unsigned MAX_STEPS  = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_req,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [7:0]    ld_data,
  input  logic          ld_last,
  input  logic          start,
  input  logic          stop,
  output logic [7:0]    dp_word,
  output logic          dp_valid,
  input  logic          dp_acc_zero,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          done,
  output logic          err
`ifdef CPU8_SEQ_SINGLE_STEP_EN
  ,
  input  logic          step,
  input  logic          step_mode
`endif
);

  seq_state_e    state_q, state_d;
  logic [AW-1:0] pc_d;
  logic [AW-1:0] ld_addr_q, ld_addr_d;
  logic [7:0]    step_q, step_d;
  logic [7:0]    settle_q, settle_d;
  logic          err_q, err_d;
  logic          mem_we;
  logic [7:0]    word;
  logic [3:0]    opc;
  logic [3:0]    opnd;
  logic          advance;
  logic          taken;

  cpu8_prog_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (ld_addr_q),
    .wdata (ld_data),
    .raddr (pc),
    .rdata (word)
  );

`ifdef CPU8_SEQ_SINGLE_STEP_EN
  assign advance = !step_mode || step;
`else
  assign advance = 1'b1;
`endif

  assign opc   = word[OPC_MSB:OPC_LSB];
  assign opnd  = word[OPND_MSB:OPND_LSB];
  assign taken = (opc == OP_JZ) ? dp_acc_zero : !dp_acc_zero;
  assign busy  = (state_q != IDLE);
  assign err   = err_q;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc;
    ld_addr_d = ld_addr_q;
    step_d    = step_q;
    settle_d  = (settle_q != '0) ? settle_q - 8'd1 : settle_q;
    err_d     = err_q;
    mem_we    = 1'b0;
    ld_ready  = 1'b0;
    dp_word   = '0;
    dp_valid  = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load_req) begin
          state_d   = LOAD;
          ld_addr_d = '0;
        end else if (start) begin
          state_d = RUN;
          pc_d    = '0;
          step_d  = '0;
          err_d   = 1'b0;
        end
      end
      LOAD: begin
        if (stop) begin
          state_d = IDLE;
        end else begin
          ld_ready = 1'b1;
          if (ld_valid) begin
            mem_we    = 1'b1;
            ld_addr_d = ld_addr_q + AW'(1);
            if (ld_last || ld_addr_q == AW'(DEPTH - 1)) state_d = IDLE;
          end
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (step_q == 8'(MAX_STEPS)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (advance) begin
          // A branch deferred to SETTLE is not counted; it counts when it resolves.
          if (opc == OP_JZ || opc == OP_JNZ) begin
            if (settle_q != '0) begin
              state_d = SETTLE;
            end else begin
              step_d = step_q + 8'd1;
              pc_d   = taken ? opnd[AW-1:0] : pc + AW'(1);
            end
          end else begin
            step_d = step_q + 8'd1;
            if (opc == OP_HALT) begin
              done    = 1'b1;
              state_d = IDLE;
            end else if (opc > OP_HALT) begin
              err_d   = 1'b1;
              state_d = IDLE;
            end else begin
              if (is_alu(opc)) begin
                dp_valid = 1'b1;
                dp_word  = word;
                settle_d = 8'(SETTLE_CYC);
              end
              if (pc == AW'(DEPTH - 1)) begin
                done    = 1'b1;
                state_d = IDLE;
              end else begin
                pc_d = pc + AW'(1);
              end
            end
          end
        end
      end
      SETTLE: begin
        if (stop) state_d = IDLE;
        else if (settle_q == '0) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pc        <= '0;
      ld_addr_q <= '0;
      step_q    <= '0;
      settle_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc        <= pc_d;
      ld_addr_q <= ld_addr_d;
      step_q    <= step_d;
      settle_q  <= settle_d;
      err_q     <= err_d;
    end
  end

endmodule
